// File: rtl/clk_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// clk_ctrl_pkg
// Shared definitions for the CPU clock-enable controller.
//   mode_t      : operating mode encoding (HALT=0, RUN=1, STEP=2)
//   decode_mode : maps a raw 2-bit mode request onto mode_t; the reserved
//                 code 3 is folded onto HALT so the controller never runs
//                 in an undefined mode.
// -----------------------------------------------------------------------------
package clk_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_HALT = 2'd0,
    MODE_RUN  = 2'd1,
    MODE_STEP = 2'd2
  } mode_t;

  function automatic mode_t decode_mode(input logic [1:0] code);
    mode_t m;
    case (code)
      2'd1:    m = MODE_RUN;
      2'd2:    m = MODE_STEP;
      default: m = MODE_HALT;  // 0 and the reserved 3
    endcase
    return m;
  endfunction

endpackage : clk_ctrl_pkg

// File: rtl/clk_ctrl_step_edge.sv
// -----------------------------------------------------------------------------
// step_edge
// Rising-edge detector for the debug step level. The level is already
// synchronous to clk; this block keeps the previous sample and flags the
// single cycle in which the level goes from 0 to 1.
// Ports:
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset (previous sample cleared)
//   i_step_req : debug step level
//   o_rise     : one-cycle pulse, high while i_step_req=1 and previous=0
// -----------------------------------------------------------------------------
module step_edge
  import clk_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_step_req,
  output logic o_rise
);

  logic r_step_prev;

  // The previous sample is tracked in every mode, so entering STEP with the
  // level already high does not look like a fresh edge.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous here: it is just another input sampled on
    // the clock edge, so it belongs inside the clocked branch, not the list.
    if (rst) begin
      r_step_prev <= 1'b0;
    end else begin
      r_step_prev <= i_step_req;
    end
  end

  assign o_rise = i_step_req & ~r_step_prev;

endmodule : step_edge

// File: rtl/clk_ctrl.sv
// -----------------------------------------------------------------------------
// clk_ctrl
// Programmable CPU clock-enable controller. Produces a registered one-cycle
// enable (ce) and a square wave (tick_clk) that toggles with every enable,
// in one of three modes: free-running divide-by-D (RUN), single step on a
// debug request (STEP), or stopped (HALT). Mode and divisor are reloaded
// through a valid/ready handshake that only opens at period boundaries, so
// the core never sees a shortened or stretched period.
// Parameters:
//   DIV_W   : divisor / counter width
//   DEF_DIV : divisor loaded at reset
// Ports:
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   cfg_valid : configuration request (held with its data until accepted)
//   cfg_ready : configuration can be accepted this cycle (combinational)
//   cfg_mode  : requested mode (0=HALT, 1=RUN, 2=STEP, 3=HALT)
//   cfg_div   : requested divisor (0 behaves as 1)
//   step_req  : debug step level, synchronous to clk
//   ce        : registered one-cycle CPU clock enable
//   tick_clk  : registered square wave, toggles in every cycle with ce=1
//   mode      : current mode
// -----------------------------------------------------------------------------
module clk_ctrl
  import clk_ctrl_pkg::*;
#(
  parameter int DIV_W   = 8,
  parameter int DEF_DIV = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [1:0]       cfg_mode,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             step_req,
  output logic             ce,
  output logic             tick_clk,
  output logic [1:0]       mode
);

  localparam logic [DIV_W-1:0] ONE       = DIV_W'(1);
  localparam logic [DIV_W-1:0] ZERO      = '0;
  localparam logic [DIV_W-1:0] RESET_DIV = DIV_W'(DEF_DIV);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  mode_t            r_mode;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_cnt;
  logic             r_step_pend;
  logic             r_ce;
  logic             r_tick;

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0] w_deff;
  logic             w_last;
  logic             w_ready;
  logic             w_accept;
  logic             w_ce_nxt;
  logic             w_step_rise;

  step_edge u_step_edge (
    .clk        (clk),
    .rst        (rst),
    .i_step_req (step_req),
    .o_rise     (w_step_rise)
  );

  // A stored divisor of zero behaves exactly like one: enable every cycle.
  assign w_deff = (r_div == ZERO) ? ONE : r_div;

  // Final count of the current period; the RUN enable and the RUN
  // reconfiguration window both hang off this single compare.
  assign w_last = (r_cnt == (w_deff - ONE));

  // NOTE: every signal driven from always_comb gets a default on its first
  // line, so no path through the block can leave it holding a value (latch).
  always_comb begin
    w_ready  = 1'b0;
    w_ce_nxt = 1'b0;
    case (r_mode)
      MODE_HALT: begin
        w_ready  = 1'b1;
        w_ce_nxt = 1'b0;
      end
      MODE_RUN: begin
        w_ready  = w_last;
        w_ce_nxt = w_last;
      end
      MODE_STEP: begin
        w_ready  = ~r_step_pend;
        w_ce_nxt = r_step_pend;
      end
      default: begin
        w_ready  = 1'b1;
        w_ce_nxt = 1'b0;
      end
    endcase
  end

  assign w_accept = cfg_valid & w_ready;

  // ---------------------------------------------------------------------------
  // Mode / counter / step controller
  // The enable is always computed from the mode in force this cycle, so a
  // RUN boundary enable still fires in the cycle after a reconfiguration.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode      <= MODE_RUN;
      r_div       <= RESET_DIV;
      r_cnt       <= ZERO;
      r_step_pend <= 1'b0;
      r_ce        <= 1'b0;
      r_tick      <= 1'b0;
    end else begin
      r_ce   <= w_ce_nxt;
      r_tick <= r_tick ^ w_ce_nxt;

      case (r_mode)
        MODE_RUN: begin
          r_cnt       <= w_last ? ZERO : (r_cnt + ONE);
          r_step_pend <= 1'b0;
        end
        MODE_STEP: begin
          r_cnt <= ZERO;
          // A pending step is consumed this cycle; an edge arriving in the
          // same cycle is dropped rather than queued behind it.
          r_step_pend <= r_step_pend ? 1'b0 : w_step_rise;
        end
        default: begin
          r_cnt       <= ZERO;
          r_step_pend <= 1'b0;
        end
      endcase

      // Accepted reconfiguration overrides the per-mode counter/step update.
      if (w_accept) begin
        r_mode      <= decode_mode(cfg_mode);
        r_div       <= cfg_div;
        r_cnt       <= ZERO;
        r_step_pend <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign cfg_ready = w_ready;
  assign ce        = r_ce;
  assign tick_clk  = r_tick;
  assign mode      = r_mode;

endmodule : clk_ctrl

// File: tb/tb_clk_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clk_ctrl
// Scoreboard bench for clk_ctrl. The driver applies one input vector per
// cycle and, from a timeline-based reference model (absolute cycle numbers
// at which enables are due, parity of enables for tick_clk), pushes the
// outputs expected in that cycle. A separate monitor pops one entry per
// cycle on the falling edge and compares ce, tick_clk, mode and cfg_ready.
// -----------------------------------------------------------------------------
module tb_clk_ctrl;

  localparam int DEF_DIV = 16;
  localparam int M_HALT  = 0;
  localparam int M_RUN   = 1;
  localparam int M_STEP  = 2;

  logic       clk;
  logic       rst;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_mode;
  logic [7:0] cfg_div;
  logic       step_req;
  logic       ce;
  logic       tick_clk;
  logic [1:0] mode;

  clk_ctrl #(.DIV_W(8), .DEF_DIV(DEF_DIV)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_mode  (cfg_mode),
    .cfg_div   (cfg_div),
    .step_req  (step_req),
    .ce        (ce),
    .tick_clk  (tick_clk),
    .mode      (mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  typedef struct {
    bit ce;
    bit tick;
    int mode;
    bit ready;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string nm, input int cyc, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0d, expected %0d", nm, cyc, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("ce",        e.cyc, int'(ce),        int'(e.ce));
      check("tick_clk",  e.cyc, int'(tick_clk),  int'(e.tick));
      check("mode",      e.cyc, int'(mode),      e.mode);
      check("cfg_ready", e.cyc, int'(cfg_ready), int'(e.ready));
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model: time-line view.
  //   next_ce  : absolute cycle of the next RUN enable
  //   fire     : absolute cycle at which a scheduled step enable fires
  //   ce_at    : set of absolute cycles carrying an enable
  //   par      : parity of enables seen since reset (= tick_clk)
  // ---------------------------------------------------------------------------
  int cyc      = 0;
  bit live     = 0;
  int mm       = M_RUN;
  int period   = DEF_DIV;
  int next_ce  = 0;
  int fire     = -1;
  bit prev_req = 0;
  bit par      = 0;
  bit ce_at[int];
  bit last_acc = 0;

  task automatic model_cycle(input bit r, input bit v, input int m, input int d, input bit s);
    bit   rdy;
    bit   acc;
    bit   edge_seen;
    exp_t e;
    if (mm == M_HALT)      rdy = 1'b1;
    else if (mm == M_STEP) rdy = (fire != cyc + 1);
    else                   rdy = (cyc + 1 == next_ce);

    if (live) begin
      e.ce = ce_at.exists(cyc);
      if (e.ce) par = ~par;
      e.tick  = par;
      e.mode  = mm;
      e.ready = rdy;
      e.cyc   = cyc;
      exp_q.push_back(e);
    end
    if (ce_at.exists(cyc)) ce_at.delete(cyc);

    acc = 1'b0;
    if (r) begin
      live    = 1'b1;
      mm      = M_RUN;
      period  = DEF_DIV;
      next_ce = cyc + 1 + DEF_DIV;
      fire    = -1;
      par     = 1'b0;
      ce_at.delete();
    end else if (live) begin
      acc       = v && rdy;
      edge_seen = s && !prev_req;
      if (mm == M_RUN && cyc + 1 == next_ce) begin
        ce_at[cyc + 1] = 1'b1;
        next_ce        = next_ce + period;
      end
      if (mm == M_STEP && edge_seen && fire != cyc + 1 && !acc) begin
        fire           = cyc + 2;
        ce_at[cyc + 2] = 1'b1;
      end
      if (acc) begin
        mm     = (m == 3) ? M_HALT : m;
        period = (d == 0) ? 1 : d;
        fire   = -1;
        if (mm == M_RUN) next_ce = cyc + 1 + period;
      end
    end
    prev_req = r ? 1'b0 : s;
    last_acc = acc;
    cyc++;
  endtask

  // ---------------------------------------------------------------------------
  // Driver
  // ---------------------------------------------------------------------------
  bit step_lvl = 0;

  task automatic tick(input bit r, input bit v, input int m, input int d, input bit s);
    rst       = r;
    cfg_valid = v;
    cfg_mode  = 2'(m);
    cfg_div   = 8'(d);
    step_req  = s;
    step_lvl  = s;
    model_cycle(r, v, m, d, s);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 0, 0, step_lvl);
  endtask

  // Hold a request until the model's ready window lets it through.
  task automatic configure(input int m, input int d);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 600 && !done; i++) begin
      tick(1'b0, 1'b1, m, d, step_lvl);
      done = last_acc;
    end
    n_vec++;
    if (!done) begin
      n_bad++;
      $display("FAIL cfg_accept: got no accept within 600 cycles, expected accept (mode %0d div %0d)", m, d);
    end
  endtask

  task automatic step_pulse(input int high, input int low);
    for (int i = 0; i < high; i++) tick(1'b0, 1'b0, 0, 0, 1'b1);
    for (int i = 0; i < low; i++)  tick(1'b0, 1'b0, 0, 0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; cfg_mode = '0; cfg_div = '0; step_req = 1'b0;
    #1;
    // Reset, then free-run at the default divisor.
    tick(1'b1, 1'b0, 0, 0, 1'b0);
    tick(1'b1, 1'b0, 0, 0, 1'b0);
    idle(50);

    // Request RUN/4 mid-period; held until the boundary.
    tick(1'b1, 1'b0, 0, 0, 1'b0);
    idle(5);
    configure(M_RUN, 4);
    idle(14);

    // STEP: two 3-cycle pulses, then a long hold.
    configure(M_STEP, 9);
    idle(3);
    step_pulse(3, 4);
    step_pulse(3, 4);
    step_pulse(12, 3);

    // HALT with step toggling, then reserved code 3.
    configure(M_HALT, 5);
    for (int i = 0; i < 4; i++) step_pulse(1, 1);
    configure(3, 7);
    idle(3);

    // Divisor 0 in RUN: enable every cycle.
    configure(M_RUN, 0);
    idle(10);

    // Reset mid-period at cnt=7 with D=16.
    configure(M_RUN, 16);
    idle(7);
    tick(1'b1, 1'b0, 0, 0, 1'b0);
    idle(20);

    // Reset while a step is pending.
    configure(M_STEP, 3);
    tick(1'b0, 1'b0, 0, 0, 1'b1);
    tick(1'b1, 1'b0, 0, 0, 1'b1);
    idle(20);
    tick(1'b0, 1'b0, 0, 0, 1'b0);

    // Randomized traffic: requests held until accepted, random resets/steps.
    begin
      bit req_on;
      int req_m;
      int req_d;
      bit r;
      req_on = 1'b0;
      req_m  = 0;
      req_d  = 0;
      for (int i = 0; i < 600; i++) begin
        if (!req_on && $urandom_range(0, 5) == 0) begin
          req_on = 1'b1;
          req_m  = $urandom_range(0, 3);
          req_d  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 6);
          if (req_d > 40) req_d = req_d % 40;
        end
        if ($urandom_range(0, 3) == 0) step_lvl = ~step_lvl;
        r = ($urandom_range(0, 79) == 0);
        tick(r, req_on, req_m, req_d, step_lvl);
        if (last_acc) req_on = 1'b0;
      end
    end

    idle(2);
    @(negedge clk);
    #1;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d entries left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    n_bad++;
    $display("FAIL timeout: got no end of stimulus, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_clk_ctrl
